// File: rtl/regfile_pkg.sv
// Shared sizing helpers and types for the regfile_scoreboard register file.
package regfile_pkg;

    function automatic int addr_w_of(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w_of(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int DEFAULT_DEPTH = 32;

    typedef logic [DEFAULT_DEPTH-1:0] busy_vec_t;

    typedef enum logic [0:0] {
        ERR_DOUBLE_ISSUE,
        ERR_WR_COLLIDE
    } sb_err_cause_e;

endpackage

// File: rtl/regfile_scoreboard_bits.sv
// Busy scoreboard for regfile_scoreboard: per-register busy bits,
// the pending-write count and the sticky error flag.
module regfile_scoreboard_bits
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int NUM_WR = 2,
    parameter int ADDR_W = addr_w_of(DEPTH),
    parameter int CNT_W  = cnt_w_of(DEPTH)
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_index,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_index,
    output logic [DEPTH-1:0]         busy,
    output logic [CNT_W-1:0]         pending_cnt,
    output logic                     sb_err
);

    logic [DEPTH-1:0] issue_vec;
    logic [DEPTH-1:0] release_vec;
    logic [DEPTH-1:0] busy_d;
    logic [DEPTH-1:0] cleared;
    logic             set_new;
    logic             double_issue;
    logic             wr_collide;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        issue_vec   = '0;
        release_vec = '0;
        wr_collide  = 1'b0;
        if (issue_en) issue_vec[issue_index] = 1'b1;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) release_vec[wr_index[w*ADDR_W +: ADDR_W]] = 1'b1;
        end
        issue_vec[0]   = 1'b0;
        release_vec[0] = 1'b0;

        // A new reservation beats a same-cycle release of the same register.
        busy_d       = (busy & ~release_vec) | issue_vec;
        cleared      = busy & ~busy_d;
        set_new      = |(issue_vec & ~busy);
        double_issue = |(issue_vec & busy & ~release_vec);
        cnt_d        = pending_cnt + CNT_W'(set_new) - CNT_W'($countones(cleared));

        for (int a = 0; a < NUM_WR; a++) begin
            for (int b = a + 1; b < NUM_WR; b++) begin
                if (wr_en[a] && wr_en[b]
                    && wr_index[a*ADDR_W +: ADDR_W] == wr_index[b*ADDR_W +: ADDR_W]
                    && wr_index[a*ADDR_W +: ADDR_W] != '0)
                    wr_collide = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            busy        <= '0;
            pending_cnt <= '0;
            sb_err      <= 1'b0;
        end else begin
            busy        <= busy_d;
            pending_cnt <= cnt_d;
            sb_err      <= sb_err | double_issue | wr_collide;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with a read-after-write busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int DEPTH     = 32,
    parameter  int NUM_RD    = 2,
    parameter  int NUM_WR    = 2,
    parameter  int DBG_INDEX = 7,
    localparam int ADDR_W    = addr_w_of(DEPTH),
    localparam int CNT_W     = cnt_w_of(DEPTH)
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic [NUM_RD*ADDR_W-1:0] rd_index,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_index,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_index,
    output logic [DATA_W-1:0]        dbg_data,
    output logic [CNT_W-1:0]         pending_cnt,
    output logic                     sb_err
);

    localparam logic [ADDR_W-1:0] DBG_ADDR = ADDR_W'(DBG_INDEX);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;

    regfile_scoreboard_bits #(
        .DEPTH  (DEPTH),
        .NUM_WR (NUM_WR),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_bits (
        .clk         (clk),
        .nRST        (nRST),
        .issue_en    (issue_en),
        .issue_index (issue_index),
        .wr_en       (wr_en),
        .wr_index    (wr_index),
        .busy        (busy),
        .pending_cnt (pending_cnt),
        .sb_err      (sb_err)
    );

    // NOTE: the array is reset because reads after reset must return zero; this keeps it in flops, not RAM.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            // Ascending port order: the last non-blocking write wins, so the higher port has priority.
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && wr_index[w*ADDR_W +: ADDR_W] != '0)
                    regs[wr_index[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
        logic              bsy;

        assign idx = rd_index[p*ADDR_W +: ADDR_W];

        always_comb begin
            data = (idx == '0) ? '0 : regs[idx];
            bsy  = busy[idx];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && idx != '0 && wr_index[w*ADDR_W +: ADDR_W] == idx) begin
                    data = wr_data[w*DATA_W +: DATA_W];
                    if (!(issue_en && issue_index == idx)) bsy = 1'b0;
                end
            end
`endif
        end

        assign rd_data[p*DATA_W +: DATA_W] = data;
        assign rd_busy[p]                  = bsy;
    end

    assign dbg_data = regs[DBG_ADDR];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed vector table, corner sequences,
// and randomized traffic against an array/popcount reference model.
`timescale 1ns/1ps
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 32;
    localparam int NUM_RD    = 2;
    localparam int NUM_WR    = 2;
    localparam int DBG_INDEX = 7;
    localparam int ADDR_W    = addr_w_of(DEPTH);
    localparam int CNT_W     = cnt_w_of(DEPTH);

    logic                     clk = 1'b0;
    logic                     nRST = 1'b0;
    logic [NUM_RD*ADDR_W-1:0] rd_index = '0;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en = '0;
    logic [NUM_WR*ADDR_W-1:0] wr_index = '0;
    logic [NUM_WR*DATA_W-1:0] wr_data = '0;
    logic                     issue_en = 1'b0;
    logic [ADDR_W-1:0]        issue_index = '0;
    logic [DATA_W-1:0]        dbg_data;
    logic [CNT_W-1:0]         pending_cnt;
    logic                     sb_err;

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .NUM_RD    (NUM_RD),
        .NUM_WR    (NUM_WR),
        .DBG_INDEX (DBG_INDEX)
    ) dut (
        .clk         (clk),
        .nRST        (nRST),
        .rd_index    (rd_index),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wr_en       (wr_en),
        .wr_index    (wr_index),
        .wr_data     (wr_data),
        .issue_en    (issue_en),
        .issue_index (issue_index),
        .dbg_data    (dbg_data),
        .pending_cnt (pending_cnt),
        .sb_err      (sb_err)
    );

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] m_regs [DEPTH];
    busy_vec_t         m_busy;
    logic              m_err;
    int                cause_cnt [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] widx(input int w);
        return wr_index[w*ADDR_W +: ADDR_W];
    endfunction

    function automatic logic [ADDR_W-1:0] ridx(input int p);
        return rd_index[p*ADDR_W +: ADDR_W];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
        m_busy = '0;
        m_err  = 1'b0;
    endtask

    // Architectural effect of one clock edge, from the register-file rules.
    task automatic model_step();
        logic [ADDR_W-1:0] i0;
        logic [ADDR_W-1:0] i1;
        bit                released;
        i0 = widx(0);
        i1 = widx(1);
        if (wr_en[0] && wr_en[1] && i0 == i1 && i0 != 0) begin
            m_err = 1'b1;
            cause_cnt[int'(ERR_WR_COLLIDE)]++;
        end
        released = (wr_en[0] && i0 == issue_index) || (wr_en[1] && i1 == issue_index);
        if (issue_en && issue_index != 0 && m_busy[issue_index] && !released) begin
            m_err = 1'b1;
            cause_cnt[int'(ERR_DOUBLE_ISSUE)]++;
        end
        if (wr_en[0] && i0 != 0) begin
            m_regs[i0] = wr_data[0 +: DATA_W];
            m_busy[i0] = 1'b0;
        end
        if (wr_en[1] && i1 != 0) begin
            m_regs[i1] = wr_data[DATA_W +: DATA_W];
            m_busy[i1] = 1'b0;
        end
        if (issue_en && issue_index != 0) m_busy[issue_index] = 1'b1;
    endtask

    function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] idx);
        logic [DATA_W-1:0] v;
        if (idx == 0) return '0;
        v = m_regs[idx];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NUM_WR; w++)
            if (wr_en[w] && widx(w) == idx) v = wr_data[w*DATA_W +: DATA_W];
`endif
        return v;
    endfunction

    function automatic logic exp_busy(input logic [ADDR_W-1:0] idx);
        logic b;
        if (idx == 0) return 1'b0;
        b = m_busy[idx];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NUM_WR; w++)
            if (wr_en[w] && widx(w) == idx && !(issue_en && issue_index == idx)) b = 1'b0;
`endif
        return b;
    endfunction

    task automatic check_all(input string tag);
        for (int p = 0; p < NUM_RD; p++) begin
            check($sformatf("%s rd_data[%0d]", tag, p), rd_data[p*DATA_W +: DATA_W], exp_rd(ridx(p)));
            check($sformatf("%s rd_busy[%0d]", tag, p), 32'(rd_busy[p]), 32'(exp_busy(ridx(p))));
        end
        check({tag, " dbg_data"}, dbg_data, m_regs[DBG_INDEX]);
        check({tag, " pending_cnt"}, 32'(pending_cnt), 32'($countones(m_busy)));
        check({tag, " sb_err"}, 32'(sb_err), 32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        wr_en    = '0;
        issue_en = 1'b0;
    endtask

    function automatic logic [ADDR_W-1:0] rnd_idx();
        if ($urandom_range(0, 3) == 0) return ADDR_W'($urandom_range(0, DEPTH - 1));
        return ADDR_W'($urandom_range(0, 7));
    endfunction

    typedef struct {
        logic [1:0]        wen;
        logic [ADDR_W-1:0] widx0;
        logic [ADDR_W-1:0] widx1;
        logic [31:0]       wd0;
        logic [31:0]       wd1;
        logic              ien;
        logic [ADDR_W-1:0] iidx;
        logic [ADDR_W-1:0] r0;
        logic [ADDR_W-1:0] r1;
        logic [31:0]       e_rd0;
        logic [31:0]       e_rd1;
        logic              e_b0;
        logic [CNT_W-1:0]  e_pend;
        logic              e_err;
    } vec_t;

    vec_t tbl [8];

    initial begin
        cause_cnt[0] = 0;
        cause_cnt[1] = 0;
        model_reset();

        //             wen    w0    w1    wd0           wd1       ien   iidx  r0    r1    e_rd0         e_rd1         b0    pend  err
        tbl[0] = '{2'b01, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0,    1'b0, 5'd0, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0, 6'd0, 1'b0};
        tbl[1] = '{2'b01, 5'd0, 5'd0, 32'h1234,     32'h0,    1'b0, 5'd0, 5'd0, 5'd3, 32'h0,        32'hDEADBEEF, 1'b0, 6'd0, 1'b0};
        tbl[2] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,    1'b1, 5'd9, 5'd9, 5'd3, 32'h0,        32'hDEADBEEF, 1'b1, 6'd1, 1'b0};
        tbl[3] = '{2'b01, 5'd9, 5'd0, 32'hA5,       32'h0,    1'b0, 5'd0, 5'd9, 5'd0, 32'hA5,       32'h0,        1'b0, 6'd0, 1'b0};
        tbl[4] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,    1'b1, 5'd4, 5'd4, 5'd9, 32'h0,        32'hA5,       1'b1, 6'd1, 1'b0};
        tbl[5] = '{2'b10, 5'd0, 5'd4, 32'h0,        32'h44,   1'b1, 5'd4, 5'd4, 5'd9, 32'h44,       32'hA5,       1'b1, 6'd1, 1'b0};
        tbl[6] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,    1'b1, 5'd4, 5'd4, 5'd0, 32'h44,       32'h0,        1'b1, 6'd1, 1'b1};
        tbl[7] = '{2'b01, 5'd4, 5'd0, 32'h99,       32'h0,    1'b0, 5'd0, 5'd4, 5'd3, 32'h99,       32'hDEADBEEF, 1'b0, 6'd0, 1'b1};

        // Reset state, observed while nRST is held low.
        rd_index = {5'd3, 5'd7};
        #2;
        check("reset rd_data0", rd_data[31:0], 32'h0);
        check("reset rd_data1", rd_data[63:32], 32'h0);
        check("reset rd_busy", 32'(rd_busy), 32'h0);
        check("reset pending_cnt", 32'(pending_cnt), 32'h0);
        check("reset sb_err", 32'(sb_err), 32'h0);
        check_all("reset");
        #1;
        nRST = 1'b1;

        // Directed vector table: apply one cycle, then read back with the strobes idle.
        for (int k = 0; k < 8; k++) begin
            wr_en       = tbl[k].wen;
            wr_index    = {tbl[k].widx1, tbl[k].widx0};
            wr_data     = {tbl[k].wd1, tbl[k].wd0};
            issue_en    = tbl[k].ien;
            issue_index = tbl[k].iidx;
            rd_index    = {tbl[k].r1, tbl[k].r0};
            tick();
            idle();
            #1;
            check($sformatf("vec%0d rd_data0", k), rd_data[31:0], tbl[k].e_rd0);
            check($sformatf("vec%0d rd_data1", k), rd_data[63:32], tbl[k].e_rd1);
            check($sformatf("vec%0d rd_busy0", k), 32'(rd_busy[0]), 32'(tbl[k].e_b0));
            check($sformatf("vec%0d pending_cnt", k), 32'(pending_cnt), 32'(tbl[k].e_pend));
            check($sformatf("vec%0d sb_err", k), 32'(sb_err), 32'(tbl[k].e_err));
            check_all($sformatf("vec%0d", k));
        end

        // Same-index write collision, then asynchronous reset mid-cycle.
        nRST = 1'b0;
        #1;
        model_reset();
        nRST = 1'b1;
        wr_en    = 2'b11;
        wr_index = {5'd5, 5'd5};
        wr_data  = {32'h22, 32'h11};
        rd_index = {5'd3, 5'd5};
        tick();
        idle();
        #1;
        check("collide rd_data", rd_data[31:0], 32'h22);
        check("collide sb_err", 32'(sb_err), 32'h1);
        #2;
        nRST = 1'b0;
        #1;
        check("async rst sb_err", 32'(sb_err), 32'h0);
        check("async rst rd_data0", rd_data[31:0], 32'h0);
        check("async rst rd_data1", rd_data[63:32], 32'h0);
        check("async rst pending_cnt", 32'(pending_cnt), 32'h0);
        check("async rst dbg_data", dbg_data, 32'h0);
        model_reset();
        #1;
        nRST = 1'b1;

        // Fill the scoreboard, then drain it two registers per cycle.
        for (int i = 1; i < DEPTH; i++) begin
            issue_en    = 1'b1;
            issue_index = ADDR_W'(i);
            tick();
            check($sformatf("fill%0d pending_cnt", i), 32'(pending_cnt), 32'($countones(m_busy)));
        end
        idle();
        rd_index = {5'd31, 5'd1};
        #1;
        check("full pending_cnt", 32'(pending_cnt), 32'd31);
        check("full rd_busy", 32'(rd_busy), 32'h3);
        check("full sb_err", 32'(sb_err), 32'h0);
        for (int i = 1; i < DEPTH; i += 2) begin
            wr_en    = (i + 1 < DEPTH) ? 2'b11 : 2'b01;
            wr_index = {ADDR_W'(i + 1), ADDR_W'(i)};
            wr_data  = {32'(i + 1) << 4, 32'(i) << 4};
            tick();
            check($sformatf("drain%0d pending_cnt", i), 32'(pending_cnt), 32'($countones(m_busy)));
        end
        idle();
        #1;
        check("empty pending_cnt", 32'(pending_cnt), 32'd0);
        check("empty rd_busy", 32'(rd_busy), 32'h0);
        check("empty sb_err", 32'(sb_err), 32'h0);
        check_all("drained");

        // Same-cycle write/read of the debug register.
        nRST = 1'b0;
        #1;
        model_reset();
        nRST = 1'b1;
        wr_en    = 2'b01;
        wr_index = {5'd0, 5'd7};
        wr_data  = {32'h0, 32'h55};
        rd_index = {5'd0, 5'd7};
        #2;
`ifdef REGFILE_BYPASS_EN
        check("bypass same-cycle rd_data", rd_data[31:0], 32'h55);
`else
        check("no-bypass same-cycle rd_data", rd_data[31:0], 32'h0);
`endif
        check("same-cycle dbg_data", dbg_data, 32'h0);
        tick();
        idle();
        #1;
        check("next-cycle rd_data", rd_data[31:0], 32'h55);
        check("next-cycle dbg_data", dbg_data, 32'h55);

        // Randomized traffic against the reference model, with periodic resets.
        for (int n = 0; n < 3000; n++) begin
            if (n % 300 == 299) begin
                nRST = 1'b0;
                #1;
                check("rand reset pending_cnt", 32'(pending_cnt), 32'h0);
                check("rand reset sb_err", 32'(sb_err), 32'h0);
                model_reset();
                nRST = 1'b1;
            end
            wr_en = 2'($urandom_range(0, 3));
            for (int w = 0; w < NUM_WR; w++) begin
                wr_index[w*ADDR_W +: ADDR_W] = rnd_idx();
                wr_data[w*DATA_W +: DATA_W]  = $urandom;
            end
            issue_en    = 1'($urandom_range(0, 1));
            issue_index = rnd_idx();
            for (int p = 0; p < NUM_RD; p++) rd_index[p*ADDR_W +: ADDR_W] = rnd_idx();
            #3;
            check_all($sformatf("rand%0d", n));
            tick();
        end

        $display("coverage: double_issue %0d write_collide %0d",
                 cause_cnt[int'(ERR_DOUBLE_ISSUE)], cause_cnt[int'(ERR_WR_COLLIDE)]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the CPU integer register file.
- Provides NUM_RD read ports and NUM_WR write ports over DEPTH registers of DATA_W bits; register 0 is hardwired to zero.
- Adds a per-register busy scoreboard so a pipelined core can stall on read-after-write hazards, plus a pending-write counter, a sticky error flag and a fixed debug tap.
- Sits between decode/issue (reserve, read) and writeback (write, release).

Parameters:
DATA_W, 32, register width in bits
DEPTH, 32, number of registers (power of two, >=2)
NUM_RD, 2, read ports (1..4)
NUM_WR, 2, write ports (1..2); higher port index has priority
DBG_INDEX, 7, register driven continuously on dbg_data
(derived) ADDR_W = $clog2(DEPTH); CNT_W = $clog2(DEPTH+1)

Ports:
clk  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
rd_index  in  NUM_RD*ADDR_W  packed read indices, port p at [p*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data
rd_busy  out  NUM_RD  register addressed by port p has a pending write
wr_en  in  NUM_WR  write strobe per port
wr_index  in  NUM_WR*ADDR_W  packed write indices
wr_data  in  NUM_WR*DATA_W  packed write data
issue_en  in  1  reserve a destination register (sets its busy bit)
issue_index  in  ADDR_W  destination being reserved
dbg_data  out  DATA_W  contents of register DBG_INDEX
pending_cnt  out  CNT_W  number of busy registers
sb_err  out  1  sticky scoreboard/port error

Behaviour:
- Reset: asynchronous and active-low. While nRST=0, all registers, busy bits, pending_cnt and sb_err are 0. Consequently rd_data=0, rd_busy=0 and dbg_data=0. Reset asserted mid-operation discards all state immediately.
- Write: on a rising edge with wr_en[w]=1 and wr_index[w]!=0, the register takes wr_data[w]. Writes to index 0 are ignored, so register 0 always reads 0.
- Write collision: if both ports write the same nonzero index in one cycle, port 1 wins and sb_err is set.
- Read: combinational from registered state, so a write is visible the cycle after its edge, unless the optional bypass is enabled. Read of index 0 returns 0 with rd_busy=0.
- Busy bits, per register i!=0, next-state priority:
  - issue_en && issue_index==i: set. A same-cycle release is overridden, because the new reservation wins.
  - Otherwise any wr_en[w] && wr_index[w]==i: clear.
  - Otherwise hold.
  - A write to a non-busy register is legal and leaves the busy bit clear.
- issue_en with issue_index==0: ignored, and busy[0] stays 0.
- issue_en to an already busy register without a same-cycle release: the bit stays set and sb_err is set (double reservation).
- rd_busy[p] = busy[rd_index[p]], combinational.
- pending_cnt:
  - Registered, and equals the popcount of the busy vector after every edge.
  - Updated incrementally: +1 per newly set bit, -1 per newly cleared bit.
  - Range 0..DEPTH-1, so it never wraps.
- sb_err: sticky once set; cleared only by reset.
- Latency: write to read is 1 cycle (0 with bypass); issue to rd_busy is 1 cycle; release to rd_busy low is 1 cycle.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: each read port forwards same-cycle write data when wr_en[w] && wr_index[w]==rd_index[p]!=0, with port 1 taking priority. rd_busy[p] is also forced to 0 when the matching write releases that register in the same cycle, unless a same-cycle issue to that index exists. dbg_data is not bypassed.
- Undefined: reads and rd_busy reflect registered state only.

Decomposition:
- Package regfile_pkg holds:
  - the localparam functions for ADDR_W and CNT_W;
  - a typedef for the busy vector;
  - an enum sb_err_cause_e (ERR_DOUBLE_ISSUE, ERR_WR_COLLIDE), used by the bench for coverage.
- One natural sub-module, regfile_scoreboard_bits, which owns the busy vector, pending_cnt and sb_err. The data array, write priority and read muxes stay in the top level.

Test Plan:
1. Reset, then write port0 idx3=0xDEADBEEF; next cycle read idx3 -> 0xDEADBEEF; read idx0 -> 0. A write to idx0 of 0x1234 -> idx0 still reads 0.
2. Both ports write idx5 (port0 0x11, port1 0x22) -> idx5 reads 0x22 and sb_err=1. Assert nRST mid-test -> sb_err=0 and all reads 0 asynchronously, before the next edge.
3. Issue idx9 -> next cycle rd_busy=1 and pending_cnt=1. Write idx9=0xA5 -> next cycle rd_busy=0, pending_cnt=0, data 0xA5.
4. In one cycle, issue idx4 and write idx4 (previously busy) -> busy stays 1, pending_cnt unchanged, sb_err=0. Then issue idx4 again with no write -> sb_err=1.
5. Reserve idx1..idx31 on consecutive cycles -> pending_cnt=31. Release all via both ports -> pending_cnt=0, no wrap.
6. With REGFILE_BYPASS_EN: write idx7=0x55 while reading idx7 in the same cycle -> rd_data=0x55 that cycle; dbg_data=0x55 only the next cycle. Without the macro: rd_data=0x55 only the next cycle.
